// File: rtl/iob_native_ram_responder.sv
// iob_native_ram_responder
// Responder end of the IOb native request/response bus. Requests are captured
// into a small FIFO on the cycle they are presented. An executor FSM then pops
// them in order, runs them against an internal word-addressed RAM, waits a
// programmable number of cycles and returns one ready pulse with rdata per
// request.
//
// Optional feature macro: IOB_NATIVE_RAM_RANGE_CHK_EN
//   defined   : accesses with any address bit set above the RAM window are
//               out of range. The write is suppressed, rdata returns 0, the
//               response is still issued and addr_err is set (sticky).
//   undefined : upper address bits are ignored, so the RAM aliases across the
//               address space, and addr_err is tied 0.
//
// Bus packing (iob_intercon field order, MSB first):
//   req  = {valid, address[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]}
//   resp = {rdata[DATA_W], ready}

module iob_native_ram_responder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_AW  = 10,
  parameter int FIFO_AW = 2,
  parameter int WAIT    = 0,
  localparam int STRB_W = DATA_W / 8,
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W,
  localparam int RESP_W = DATA_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQ_W-1:0]  req,
  output logic [RESP_W-1:0] resp,
  output logic              overflow,
  output logic              addr_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_CNT = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [7:0] WAIT_CNT = 8'(WAIT);

  // One buffered request as it sits in the FIFO
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Request field extraction
  logic              req_valid;
  entry_t            req_entry;

  assign req_valid       = req[REQ_W-1];
  assign req_entry.addr  = req[REQ_W-2 -: ADDR_W];
  assign req_entry.wdata = req[STRB_W +: DATA_W];
  assign req_entry.wstrb = req[0 +: STRB_W];

  // FIFO state
  entry_t             fifo_mem [DEPTH];
  logic [FIFO_AW:0]   wr_ptr;
  logic [FIFO_AW:0]   rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               drop;
  entry_t             head;

  // Executor state
  state_t             state;
  state_t             next_state;
  logic [7:0]         cnt;
  logic [7:0]         cnt_next;
  logic               do_pop;
  logic               ready;
  logic [DATA_W-1:0]  rdata_q;

  // RAM and head-of-FIFO decode
  logic [DATA_W-1:0]  mem [2**MEM_AW];
  logic [MEM_AW-1:0]  mem_idx;
  logic               head_write;
  logic               head_oor;
  logic               mem_we;
  logic               unused_addr_bits;

  assign count      = wr_ptr - rd_ptr;
  assign fifo_full  = (count == DEPTH_CNT);
  assign fifo_empty = (wr_ptr == rd_ptr);

  // A pop in the same cycle frees a slot, so a full FIFO still accepts then.
  // A pop never happens on an empty FIFO, so a push into an empty FIFO is
  // only visible to the executor from the next cycle on.
  assign push = req_valid && (!fifo_full || do_pop);
  assign drop = req_valid && fifo_full && !do_pop;

  assign head       = fifo_mem[rd_ptr[FIFO_AW-1:0]];
  assign mem_idx    = head.addr[MEM_AW+1:2];
  assign head_write = |head.wstrb;

  // Byte offset bits never matter, and upper bits only matter with range checking
  assign unused_addr_bits = ^head.addr;

`ifdef IOB_NATIVE_RAM_RANGE_CHK_EN
  assign head_oor = |(head.addr >> (MEM_AW + 2));

  // Sticky out-of-range flag, raised the cycle after the offending pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_err <= 1'b0;
    end else if (do_pop && head_oor) begin
      addr_err <= 1'b1;
    end
  end
`else
  assign head_oor = 1'b0;
  assign addr_err = 1'b0;
`endif

  assign mem_we = do_pop && head_write && !head_oor;

  // FIFO entry storage; no reset needed since only occupied slots are read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[FIFO_AW-1:0]] <= req_entry;
    end
  end

  // FIFO pointers, one extra bit so full and empty can be told apart
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Sticky drop flag, raised the cycle after a request hits a full FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  // RAM byte-lane writes; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (head.wstrb[b]) begin
          mem[mem_idx][8*b +: 8] <= head.wdata[8*b +: 8];
        end
      end
    end
  end

  // Read data is captured at pop and held until the next pop; writes and
  // out-of-range accesses return zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (do_pop) begin
      if (head_write || head_oor) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= mem[mem_idx];
      end
    end
  end

  // Executor state and wait counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Executor next state: pop from IDLE or RESP, count down in WAIT, and
  // pulse ready for the single RESP cycle
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    do_pop     = 1'b0;
    ready      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          do_pop     = 1'b1;
          cnt_next   = WAIT_CNT;
          next_state = (WAIT_CNT != 8'd0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_next = cnt - 8'd1;
        if (cnt <= 8'd1) begin
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        ready = 1'b1;
        if (!fifo_empty) begin
          do_pop     = 1'b1;
          cnt_next   = WAIT_CNT;
          next_state = (WAIT_CNT != 8'd0) ? ST_WAIT : ST_RESP;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  assign resp = {rdata_q, ready};

endmodule

// File: doc/iob_native_ram_responder.md
# iob_native_ram_responder

Responder (slave) end of the IOb native request/response bus: accepts requests driven by an initiator such as the VexRiscv core wrapper's instruction or data port, buffers them in a small FIFO, executes them against an internal word-addressed RAM with programmable wait states and returns one `ready` pulse with `rdata` per request, in order. It sits behind the system interconnect as a boot/scratch memory and doubles as a latency-controllable bus model for CPU verification. Initiators may drop `valid` after a single cycle without waiting for the response, so every request is captured the cycle it is presented.

## Interface
- `ADDR_W`, 32, request address width (bytes).
- `DATA_W`, 32, data width; `DATA_W/8` strobe bits.
- `MEM_AW`, 10, RAM word-address width (2^MEM_AW words).
- `FIFO_AW`, 2, request FIFO depth 2^FIFO_AW entries.
- `WAIT`, 0, extra wait cycles per transaction (0..255).

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `req`  in  `REQ_W`  concatenated request: `valid`, `address`, `wdata`, `wstrb` via the `iob_intercon.vh` field macros.
- `resp`  out  `RESP_W`  concatenated response: `rdata`, `ready`.
- `overflow`  out  1  sticky: a request was dropped on a full FIFO.
- `addr_err`  out  1  sticky: out-of-range access (see Configuration).

## Operation
- Request = cycle with `valid`=1. `wstrb`≠0 is a write (byte lanes per strobe bit); `wstrb`=0 is a read. No backpressure: responder never stalls the initiator.
- Push: entry {address, wdata, wstrb} written to FIFO when `valid` && (!full || pop this cycle). `valid` while full with no simultaneous pop: request dropped, no response ever issued, `overflow` set.
- Executor FSM, states IDLE, WAIT, RESP:
  - IDLE: if FIFO non-empty, pop; perform write (strobed byte lanes of word `address[MEM_AW+1:2]`) or latch read word into `rdata` register (writes latch 0); load wait counter with `WAIT`; go WAIT if `WAIT`>0 else RESP.
  - WAIT: decrement counter; at 1 go RESP.
  - RESP: `ready`=1 for exactly this cycle, `rdata` valid; if FIFO non-empty pop (same actions as IDLE) and go WAIT/RESP, else IDLE.
- `rdata` held from pop until next pop; outside `ready` cycles its value is don't-care for the initiator but must not be X after reset.
- Ordering: strict FIFO; a read popped after a write to the same word returns the written data.
- Address bits [1:0] ignored; byte placement is entirely by `wstrb`.

## Timing
- Reset values: `ready`=0, `rdata`=0, `overflow`=0, `addr_err`=0, FIFO empty, FSM IDLE, counter 0. RAM contents not reset.
- Reset asserted mid-transaction: FIFO flushed, pending responses discarded, no `ready` after release until a new request.
- Uncongested latency: `valid` in cycle T -> `ready` in cycle T+2+WAIT.
- Back-to-back throughput: one response every WAIT+1 cycles (WAIT=0: `ready` every cycle once pipeline filled).
- FIFO pointers FIFO_AW+1 bits, wrap modulo 2^FIFO_AW; full = count 2^FIFO_AW, empty = count 0; simultaneous push and pop on full or empty handled (count unchanged, on empty the pushed entry is not popped that cycle).
- `overflow`/`addr_err` set on the cycle after the event; clear only by reset.

## Configuration
- `IOB_NATIVE_RAM_RANGE_CHK_EN` defined: at pop, any set bit in `address[ADDR_W-1:MEM_AW+2]` marks the access out of range: write suppressed, `rdata`=0, response still returned with normal latency, `addr_err` set.
- Not defined: upper address bits ignored (RAM aliases across the address space), `addr_err` tied 0.

## Test plan
- Reset: `rst`=0 then 1, no requests -> `resp` all 0, `overflow`=0, `addr_err`=0 for 20 cycles.
- WAIT=0: one-cycle write addr 0x10 data 0xDEADBEEF strb 0xF, then one-cycle read 0x10 -> write `ready` at T+2, read `ready` at next cycle with `rdata`=0xDEADBEEF.
- Byte strobes: write 0x11223344 strb 0xF, write 0x000000AA strb 0x1 to 0x20, read 0x20 -> `rdata`=0x112233AA.
- WAIT=3: single read at cycle T -> `ready` exactly at T+5, one cycle wide; 4 back-to-back reads -> `ready` at T+5, T+9, T+13, T+17.
- Overflow (FIFO_AW=2, WAIT=7): 8 consecutive one-cycle requests -> first 5 or fewer answered as buffered, remainder dropped, `overflow`=1 sticky, responses in issue order.
- With `IOB_NATIVE_RAM_RANGE_CHK_EN`, MEM_AW=10: write 0x5 to 0x1000 then read 0x0 -> write answered, `addr_err`=1, read returns old word 0 (no aliasing).
